// File: rtl/rvsteel_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to the bus from BASE_ADDRESS.
// Optional readback check of every written word is enabled by defining LOADER_VERIFY_EN.
module rvsteel_stream_loader #(
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
   parameter int          LOAD_SIZE    = 8192
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] error_address,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] rw_address,
   output logic [31:0] write_data,
   output logic [3:0]  write_strobe,
   output logic        write_request,
   input  logic        write_response,
   input  logic [31:0] read_data,
   output logic        read_request,
   input  logic        read_response
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
`ifdef LOADER_VERIFY_EN
      VERIFY  = 3'd3,
`endif
      FINISH  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        word_ok;
`ifdef LOADER_VERIFY_EN
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         cnt_q      <= 32'd0;
         done_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
         err_q      <= 1'b0;
         err_addr_q <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
`ifdef LOADER_VERIFY_EN
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      word_ok    = 1'b0;
`ifdef LOADER_VERIFY_EN
      err_d      = err_q;
      err_addr_d = err_addr_q;
`endif
      case (state_q)
         IDLE, FINISH: begin
            if (start) begin
               state_d    = COLLECT;
               addr_d     = BASE_ADDRESS;
               data_d     = 32'd0;
               cnt_d      = 32'd0;
               done_d     = 1'b0;
`ifdef LOADER_VERIFY_EN
               err_d      = 1'b0;
               err_addr_d = 32'd0;
`endif
            end
         end
         COLLECT: begin
            if (in_valid) begin
               // Shifting in from the top leaves the first byte in [7:0] after four bytes.
               data_d = {in_data, data_q[31:8]};
               cnt_d  = cnt_q + 32'd1;
               if (cnt_q[1:0] == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            if (write_response) begin
`ifdef LOADER_VERIFY_EN
               state_d = VERIFY;
`else
               word_ok = 1'b1;
`endif
            end
         end
`ifdef LOADER_VERIFY_EN
         VERIFY: begin
            if (read_response) begin
               if (read_data != data_q) begin
                  err_d      = 1'b1;
                  err_addr_d = addr_q;
                  done_d     = 1'b1;
                  state_d    = FINISH;
               end else begin
                  word_ok = 1'b1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      if (word_ok) begin
         addr_d = addr_q + 32'd4;
         if (cnt_q == 32'(LOAD_SIZE)) begin
            state_d = FINISH;
            done_d  = 1'b1;
         end else begin
            state_d = COLLECT;
         end
      end
   end

   assign busy          = (state_q == COLLECT) || (state_q == WRITE)
`ifdef LOADER_VERIFY_EN
                          || (state_q == VERIFY)
`endif
                          ;
   assign done          = done_q;
   assign in_ready      = (state_q == COLLECT);
   assign rw_address    = addr_q;
   assign write_data    = data_q;
   assign write_request = (state_q == WRITE);
   assign write_strobe  = (state_q == WRITE) ? 4'b1111 : 4'b0000;

`ifdef LOADER_VERIFY_EN
   assign read_request  = (state_q == VERIFY);
   assign error         = err_q;
   assign error_address = err_addr_q;
`else
   logic unused_read;
   assign unused_read   = ^{read_data, read_response};
   assign read_request  = 1'b0;
   assign error         = 1'b0;
   assign error_address = 32'd0;
`endif

endmodule

// File: tb/tb_rvsteel_stream_loader.sv
// Randomized directed bench for rvsteel_stream_loader: expected bus writes are rebuilt from the byte list.
module tb_rvsteel_stream_loader;
   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int          LSIZE = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset = 1'b1, start = 1'b0;
   logic        busy, done, error, in_ready, write_request, read_request;
   logic [31:0] error_address, rw_address, write_data;
   logic [3:0]  write_strobe;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0, write_response = 1'b0, read_response = 1'b0;
   logic [31:0] read_data = 32'h0;

   int n_assert = 0, n_fail = 0;

   rvsteel_stream_loader #(.BASE_ADDRESS(BASE), .LOAD_SIZE(LSIZE)) u_dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .error(error), .error_address(error_address), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .rw_address(rw_address),
      .write_data(write_data), .write_strobe(write_strobe),
      .write_request(write_request), .write_response(write_response),
      .read_data(read_data), .read_request(read_request),
      .read_response(read_response));

   // Second instance sitting at the top of the address space, zero-wait bus.
   logic        w_start = 1'b0, w_busy, w_done, w_error, w_in_ready, w_wreq, w_rreq;
   logic [31:0] w_erraddr, w_addr, w_wdata, w_last = 32'h0;
   logic [3:0]  w_wstrb;
   logic [7:0]  w_cnt = 8'h00;
   logic        w_in_valid, w_wresp, w_rresp;
   logic [31:0] w_rdata;
   logic [31:0] w_addr_q[$], w_data_q[$];
   assign w_in_valid = 1'b1;
   assign w_wresp    = w_wreq;
   assign w_rresp    = w_rreq;
   assign w_rdata    = w_last;

   rvsteel_stream_loader #(.BASE_ADDRESS(32'hFFFF_FFFC), .LOAD_SIZE(8)) u_wrap (
      .clock(clock), .reset(reset), .start(w_start), .busy(w_busy), .done(w_done),
      .error(w_error), .error_address(w_erraddr), .in_data(w_cnt),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .rw_address(w_addr),
      .write_data(w_wdata), .write_strobe(w_wstrb),
      .write_request(w_wreq), .write_response(w_wresp),
      .read_data(w_rdata), .read_request(w_rreq), .read_response(w_rresp));

   always @(posedge clock or negedge reset)
      if (!reset) w_cnt <= 8'h00;
      else if (w_in_ready) w_cnt <= w_cnt + 8'h01;

   always @(negedge clock)
      if (w_wreq) begin
         w_addr_q.push_back(w_addr);
         w_data_q.push_back(w_wdata);
         w_last = w_wdata;
      end

   // Byte stream source: mode 0 continuous, 1 every other cycle, 2 random.
   logic [7:0] stim[$];
   int         sidx = 0, vmode = 0;
   bit         took = 1'b0, phase = 1'b0;
   always @(negedge clock) begin
      if (took) sidx++;
      if (sidx < stim.size() && (vmode == 0 || (vmode == 1 && phase) ||
                                 (vmode == 2 && $urandom_range(0, 1) == 1))) begin
         in_valid = 1'b1;
         in_data  = stim[sidx];
      end else begin
         in_valid = 1'b0;
         in_data  = 8'h00;
      end
      phase = !phase;
      took  = in_valid && in_ready;
   end

   // Bus device with programmable wait states and optional spurious acknowledges.
   logic [31:0] wr_addr_q[$], wr_data_q[$];
   int          hold_q[$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] h_addr, h_data, bad_addr = 32'h0;
   int          hold = 0, cur_wait = 0, fix_wait = 0, stab_err = 0, n_reads = 0;
   bit          rnd_wait = 1'b0, spur = 1'b0, bad_en = 1'b0, prev_resp = 1'b0;
   always @(negedge clock) begin
      if (write_request) begin
         if (prev_resp) stab_err++;
         if (hold == 0) begin
            cur_wait = rnd_wait ? int'($urandom_range(0, 4)) : fix_wait;
            h_addr   = rw_address;
            h_data   = write_data;
         end else if (rw_address !== h_addr || write_data !== h_data) begin
            stab_err++;
         end
         if (write_strobe !== 4'hF) stab_err++;
         hold++;
         if (hold > cur_wait) begin
            write_response = 1'b1;
            wr_addr_q.push_back(rw_address);
            wr_data_q.push_back(write_data);
            hold_q.push_back(hold);
            mem[rw_address] = write_data;
            hold = 0;
         end else begin
            write_response = 1'b0;
         end
      end else begin
         hold = 0;
         write_response = spur && ($urandom_range(0, 3) == 0);
      end
      prev_resp = write_response && write_request;
      if (read_request) begin
         n_reads++;
         read_response = 1'b1;
         if (bad_en && rw_address == bad_addr) read_data = 32'hDEAD_BEEF;
         else read_data = mem.exists(rw_address) ? mem[rw_address] : 32'h0;
      end else begin
         read_response = spur && ($urandom_range(0, 3) == 0);
         read_data = $urandom();
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input string tag, input int mode, input int wait_cfg,
                          input bit fixed_bytes, input bit poke, input bit exp_err);
      logic [31:0] ew;
      int k;
      wr_addr_q.delete(); wr_data_q.delete(); hold_q.delete();
      stab_err = 0;
      stim.delete();
      for (int i = 0; i < LSIZE; i++)
         stim.push_back(fixed_bytes ? 8'(8'h11 * (i + 1)) : 8'($urandom));
      sidx = 0; took = 1'b0; vmode = mode;
      rnd_wait = (wait_cfg < 0);
      fix_wait = (wait_cfg < 0) ? 0 : wait_cfg;
      start = 1'b1; step(1); start = 1'b0;
      chk({tag, " busy_after_start"}, busy, 1);
      chk({tag, " done_cleared"}, done, 0);
      chk({tag, " first_address"}, rw_address, BASE);
      if (poke) begin
         step(2); start = 1'b1; step(1); start = 1'b0;
      end
      k = 0;
      while (done !== 1'b1 && k < 400) begin step(1); k++; end
      chk({tag, " done_within_budget"}, done, 1);
      step(5);
      chk({tag, " busy_in_finish"}, busy, 0);
      chk({tag, " done_sticky"}, done, 1);
      chk({tag, " write_count"}, wr_addr_q.size(), LSIZE / 4);
      if (wr_addr_q.size() == LSIZE / 4)
         for (int i = 0; i < LSIZE / 4; i++) begin
            ew = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            chk($sformatf("%s addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
            chk($sformatf("%s data%0d", tag, i), wr_data_q[i], ew);
         end
      chk({tag, " bus_protocol"}, stab_err, 0);
      chk({tag, " error"}, error, exp_err);
      chk({tag, " error_address"}, error_address, exp_err ? BASE + 32'd4 : 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      int k;
      #2 reset = 1'b0;
      step(2);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset in_ready", in_ready, 0);
      chk("reset write_request", write_request, 0);
      chk("reset rw_address", rw_address, 0);
      chk("reset write_strobe", write_strobe, 0);
      chk("reset error", {error, read_request}, 0);
      chk("reset error_address", error_address, 0);
      reset = 1'b1;
      step(2);

      w_start = 1'b1; step(1); w_start = 1'b0;
      do_load("basic", 0, 0, 1'b1, 1'b0, 1'b0);
      chk("wrap write_count", w_addr_q.size(), 2);
      if (w_addr_q.size() == 2) begin
         chk("wrap addr0", w_addr_q[0], 32'hFFFF_FFFC);
         chk("wrap addr1", w_addr_q[1], 32'h0000_0000);
         chk("wrap data0", w_data_q[0], 32'h0302_0100);
         chk("wrap data1", w_data_q[1], 32'h0706_0504);
      end
      chk("wrap error", w_error, 0);
      chk("wrap done", w_done, 1);

      do_load("wait5", 0, 5, 1'b0, 1'b0, 1'b0);
      chk("wait5 hold_count", hold_q.size(), 2);
      if (hold_q.size() == 2) begin
         chk("wait5 hold0", hold_q[0], 6);
         chk("wait5 hold1", hold_q[1], 6);
      end
      do_load("toggle", 1, -1, 1'b0, 1'b0, 1'b0);
      spur = 1'b1;
      for (int r = 0; r < 5; r++)
         do_load($sformatf("rand%0d", r), 2, -1, 1'b0, (r % 2) == 1, 1'b0);
      spur = 1'b0;

      // Reset in the middle of a stalled write.
      stim.delete();
      for (int i = 0; i < LSIZE; i++) stim.push_back(8'($urandom));
      sidx = 0; took = 1'b0; vmode = 0; rnd_wait = 1'b0; fix_wait = 20;
      start = 1'b1; step(1); start = 1'b0;
      k = 0;
      while (write_request !== 1'b1 && k < 50) begin step(1); k++; end
      chk("midreset request_seen", write_request, 1);
      step(2);
      reset = 1'b0;
      #1;
      chk("midreset write_request", write_request, 0);
      chk("midreset rw_address", rw_address, 0);
      chk("midreset write_data", write_data, 0);
      chk("midreset write_strobe", write_strobe, 0);
      chk("midreset busy_done", {busy, done, in_ready}, 0);
      step(1);
      reset = 1'b1;
      step(2);
      do_load("after_reset", 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_VERIFY_EN
      bad_en = 1'b1; bad_addr = BASE + 32'd4;
      do_load("verify_err", 0, 0, 1'b1, 1'b0, 1'b1);
      bad_en = 1'b0;
      do_load("verify_ok", 2, -1, 1'b0, 1'b0, 1'b0);
`else
      chk("no_read_requests", n_reads, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
